// File: rtl/fnc_vgacapture.sv
// VGA input capture: samples a sync+RGB stream and writes active pixels to VRAM.
// Define FNC_VGACAPTURE_CHECK_EN to enable the line/frame timing checker.
module fnc_vgacapture #(
    parameter int unsigned H_PIXELS      = 640,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC        = 64,
    parameter int unsigned H_BACK_PORCH  = 80,
    parameter int unsigned V_PIXELS      = 480,
    parameter int unsigned V_FRONT_PORCH = 3,
    parameter int unsigned V_SYNC        = 4,
    parameter int unsigned V_BACK_PORCH  = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        module_en,
    input  logic        err_clr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  rdata,
    input  logic [3:0]  gdata,
    input  logic [3:0]  bdata,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_wdata,
    output logic        vram_we,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_err
);

    localparam int unsigned CW        = 10;
    localparam int unsigned AW        = 19;
    localparam int unsigned DW        = 12;
    localparam int unsigned H_TOTAL   = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int unsigned V_TOTAL   = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int unsigned H_ACT_LO  = H_SYNC + H_BACK_PORCH;
    localparam int unsigned H_ACT_HI  = H_ACT_LO + H_PIXELS;
    localparam int unsigned V_ACT_LO  = V_SYNC + V_BACK_PORCH;
    localparam int unsigned V_ACT_HI  = V_ACT_LO + V_PIXELS;
    localparam int unsigned HCNT_MAX  = 1023;
    localparam int unsigned VCNT_PRE  = 1023;
    localparam int unsigned VCNT_MAX  = 1022;
    localparam int unsigned ADDR_LAST = H_PIXELS * V_PIXELS - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_hs1, r_vs1, r_hs2, r_vs2;
    logic [DW-1:0]   r_pix1, r_pix2;
    logic [CW-1:0]   r_hcnt, r_vcnt;
    logic            r_vs_rise2;
    logic [AW-1:0]   r_next_addr;
    logic            r_full;

    logic            w_hs_fall, w_vs_rise;
    logic [CW-1:0]   w_hcnt_inc, w_hcnt_nxt, w_vcnt_inc, w_vcnt_nxt;
    logic            w_line_ok, w_frame_ok;
    logic            w_err;
    logic            w_wr_ok, w_lock_nxt, w_serr_nxt;
    logic            w_in_win, w_wr;

    // Input pin registers; second stage gives the previous sample for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b0;
            r_pix1 <= '0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b0;
            r_pix2 <= '0;
        end else begin
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
            r_pix1 <= {rdata, gdata, bdata};
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_pix2 <= r_pix1;
        end
    end

    // Counter next values; a vsync rise is applied before a coincident hsync fall
    always_comb begin
        w_hs_fall  = r_hs2 & ~r_hs1;
        w_vs_rise  = ~r_vs2 & r_vs1;
        w_hcnt_inc = (r_hcnt == CW'(HCNT_MAX)) ? r_hcnt : r_hcnt + CW'(1);
        w_hcnt_nxt = w_hs_fall ? '0 : w_hcnt_inc;
        if (r_vcnt == CW'(VCNT_PRE)) begin
            w_vcnt_inc = '0;
        end else if (r_vcnt == CW'(VCNT_MAX)) begin
            w_vcnt_inc = r_vcnt;
        end else begin
            w_vcnt_inc = r_vcnt + CW'(1);
        end
        if (w_vs_rise) begin
            w_vcnt_nxt = w_hs_fall ? '0 : CW'(VCNT_PRE);
        end else if (w_hs_fall) begin
            w_vcnt_nxt = w_vcnt_inc;
        end else begin
            w_vcnt_nxt = r_vcnt;
        end
        w_line_ok  = (r_hcnt == CW'(H_TOTAL - 1));
        w_frame_ok = (r_vcnt == CW'(V_TOTAL - 1));
    end

`ifdef FNC_VGACAPTURE_CHECK_EN
    logic r_skip;

    always_comb begin
        w_err = 1'b0;
        if (r_state == ST_CAPTURE) begin
            w_err = (w_hs_fall & ~r_skip & ~w_line_ok)
                  | ((w_hcnt_nxt == CW'(HCNT_MAX)) & (r_hcnt != CW'(HCNT_MAX)))
                  | (w_vs_rise & ~w_frame_ok);
        end
    end

    // The line in progress when capture starts has an unknown start, so skip its length check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip <= 1'b0;
        end else if (!module_en) begin
            r_skip <= 1'b0;
        end else if ((r_state != ST_CAPTURE) && (w_state_nxt == ST_CAPTURE)) begin
            r_skip <= 1'b1;
        end else if ((r_state == ST_CAPTURE) && w_hs_fall) begin
            r_skip <= 1'b0;
        end
    end
`else
    logic w_unused_chk;
    assign w_err        = 1'b0;
    assign w_unused_chk = err_clr ^ w_line_ok ^ w_frame_ok;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = ST_SEARCH;
            ST_SEARCH:  if (w_vs_rise) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_err) w_state_nxt = ST_SEARCH;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (!module_en) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        w_wr_ok    = (r_state == ST_CAPTURE);
`ifdef FNC_VGACAPTURE_CHECK_EN
        w_lock_nxt = (w_state_nxt == ST_CAPTURE) & ~w_err
                   & (locked | ((r_state == ST_CAPTURE) & w_vs_rise));
        w_serr_nxt = (r_state != ST_IDLE) & (w_err | (sync_err & ~err_clr));
`else
        w_lock_nxt = (w_state_nxt == ST_CAPTURE);
        w_serr_nxt = 1'b0;
`endif
    end

    // Timing counters and status, aligned with the second pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_vs_rise2 <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else if (!module_en) begin
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_vs_rise2 <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            r_hcnt     <= w_hcnt_nxt;
            r_vcnt     <= w_vcnt_nxt;
            r_vs_rise2 <= w_vs_rise;
            locked     <= w_lock_nxt;
            sync_err   <= w_serr_nxt;
        end
    end

    always_comb begin
        w_in_win = (r_hcnt >= CW'(H_ACT_LO)) && (r_hcnt < CW'(H_ACT_HI))
                && (r_vcnt >= CW'(V_ACT_LO)) && (r_vcnt < CW'(V_ACT_HI));
        w_wr     = w_wr_ok & w_in_win & ~r_full & ~r_vs_rise2;
    end

    // VRAM write port; the address restarts at every vsync rise and stops after the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr   <= '0;
            vram_wdata  <= '0;
            vram_we     <= 1'b0;
            frame_done  <= 1'b0;
            r_next_addr <= '0;
            r_full      <= 1'b0;
        end else if (!module_en) begin
            vram_addr   <= '0;
            vram_wdata  <= '0;
            vram_we     <= 1'b0;
            frame_done  <= 1'b0;
            r_next_addr <= '0;
            r_full      <= 1'b0;
        end else begin
            vram_we    <= w_wr;
            frame_done <= vram_we & (vram_addr == AW'(ADDR_LAST));
            if (r_vs_rise2) begin
                vram_addr   <= '0;
                r_next_addr <= '0;
                r_full      <= 1'b0;
            end else if (w_wr) begin
                vram_addr   <= r_next_addr;
                vram_wdata  <= r_pix2;
                r_next_addr <= r_next_addr + AW'(1);
                r_full      <= (r_next_addr == AW'(ADDR_LAST));
            end
        end
    end

endmodule
